tx_channel_scheduler: RTL and testbench

// Sequences readout of the per-channel result FIFOs that sit behind the FIR/normalisation stage.

---
 rtl/tx_channel_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tx_channel_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_channel_scheduler.sv
// tx_channel_scheduler: drains the per-channel result FIFOs in ascending
// channel order onto one valid/ready stream, CNT words per enabled channel,
// and marks the last word of the frame.
module tx_channel_scheduler #(
    parameter int NCH = 22,
    parameter int CNT = 1000,
    parameter int DW  = 32,
    parameter int CW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [NCH-1:0]    fifo_empty,
    output logic [NCH-1:0]    fifo_rd_en,
    input  logic [NCH*DW-1:0] fifo_dout,
    output logic [DW-1:0]     m_tdata,
    output logic [CW-1:0]     m_tchan,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              done
);
    localparam int WCW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(CNT - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    // Lowest set mask bit at or above index lo (0 when there is none).
    function automatic logic [CW-1:0] first_set(input logic [NCH-1:0] m, input int lo);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) idx = CW'(i);
        end
        return idx;
    endfunction

    // True when any mask bit at or above index lo is set.
    function automatic logic any_set(input logic [NCH-1:0] m, input int lo);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (m[i] && (i >= lo)) hit = 1'b1;
        end
        return hit;
    endfunction

    state_t          state, state_next;
    logic [NCH-1:0]  mask_q;
    logic [CW-1:0]   cur_ch;
    logic [WCW-1:0]  word_cnt;

    // Read issued last cycle; its data lands on fifo_dout this cycle.
    logic            rd_vld_p1;
    logic [CW-1:0]   rd_ch_p1;
    logic            rd_last_p1;

    // Two-entry output buffer, FIFO order.
    logic [DW-1:0]   buf_data [2];
    logic [CW-1:0]   buf_chan [2];
    logic            buf_last [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      count, count_next;

    logic            has_stored, out_vld, pop, land_wr, buf_rd, room;
    logic            word_last, ch_last, issue;
    logic [CW-1:0]   next_ch;
    logic [DW-1:0]   land_data, head_data;
    logic [CW-1:0]   head_chan;
    logic            head_last;

    // Buffer head selection, read-issue decision and occupancy bookkeeping.
    // A landing word is presented directly when the buffer is empty so the
    // first word appears one cycle after its read strobe.
    always_comb begin
        has_stored = (count != 2'd0);
        out_vld    = has_stored | rd_vld_p1;
        pop        = out_vld & m_tready;
        land_data  = fifo_dout[int'(rd_ch_p1) * DW +: DW];
        head_data  = has_stored ? buf_data[rd_ptr] : land_data;
        head_chan  = has_stored ? buf_chan[rd_ptr] : rd_ch_p1;
        head_last  = has_stored ? buf_last[rd_ptr] : rd_last_p1;
        land_wr    = rd_vld_p1 & ~(~has_stored & pop);
        buf_rd     = has_stored & pop;
        count_next = count + {1'b0, land_wr} - {1'b0, buf_rd};
        // stored + inflight - pop < 2, rearranged to avoid underflow
        room       = ({1'b0, count} + {2'b00, rd_vld_p1}) < (3'd2 + {2'b00, pop});
        word_last  = (word_cnt == LAST_WORD);
        ch_last    = !any_set(mask_q, int'(cur_ch) + 1);
        next_ch    = first_set(mask_q, int'(cur_ch) + 1);
        issue      = (state == READ) && !fifo_empty[cur_ch] && room;
    end

    // Next-state logic and outputs.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (ch_mask != '0) ? READ : DONE;
            READ:    if (issue && word_last && ch_last) state_next = DRAIN;
            DRAIN:   if (count_next == 2'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        fifo_rd_en = issue ? (NCH'(1) << cur_ch) : '0;
        m_tvalid   = out_vld;
        m_tdata    = out_vld ? head_data : '0;
        m_tchan    = out_vld ? head_chan : '0;
        m_tlast    = out_vld & head_last;
        busy       = (state == READ) || (state == DRAIN);
        done       = (state == DONE);
    end

    // Control state: FSM, channel/word sequencing, in-flight tracking, buffer pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask_q     <= '0;
            cur_ch     <= '0;
            word_cnt   <= '0;
            rd_vld_p1  <= 1'b0;
            rd_ch_p1   <= '0;
            rd_last_p1 <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && start && (ch_mask != '0)) begin
                mask_q   <= ch_mask;
                cur_ch   <= first_set(ch_mask, 0);
                word_cnt <= '0;
            end else if (issue) begin
                if (word_last) begin
                    word_cnt <= '0;
                    cur_ch   <= next_ch;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            rd_vld_p1  <= issue;
            rd_ch_p1   <= cur_ch;
            rd_last_p1 <= word_last & ch_last;
            if (land_wr) wr_ptr <= ~wr_ptr;
            if (buf_rd)  rd_ptr <= ~rd_ptr;
            count <= count_next;
        end
    end

    // Buffer storage: capture a landing word that is not consumed this cycle.
    always_ff @(posedge clk) begin
        if (land_wr) begin
            buf_data[wr_ptr] <= land_data;
            buf_chan[wr_ptr] <= rd_ch_p1;
            buf_last[wr_ptr] <= rd_last_p1;
        end
    end

endmodule

// File: tb/tb_tx_channel_scheduler.sv
// Testbench for tx_channel_scheduler: behavioural channel FIFOs, directed
// frames, and a scoreboard monitor checking every output handshake.
module tb_tx_channel_scheduler;
    localparam int NCH = 4;
    localparam int CNT = 8;
    localparam int DW  = 32;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [NCH-1:0]    ch_mask;
    logic [NCH-1:0]    fifo_empty;
    logic [NCH-1:0]    fifo_rd_en;
    logic [NCH*DW-1:0] fifo_dout;
    logic [DW-1:0]     m_tdata;
    logic [CW-1:0]     m_tchan;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              busy;
    logic              done;

    tx_channel_scheduler #(.NCH(NCH), .CNT(CNT), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .m_tdata(m_tdata), .m_tchan(m_tchan), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          l;
    } beat_t;

    beat_t          exp_q[$];
    beat_t          mon_e;
    beat_t          prev_beat;
    logic           prev_stall = 1'b0;
    int             n_total = 0;
    int             n_pass  = 0;
    int             frame_id = 0;
    logic           fifo_clear = 1'b0;
    logic [NCH-1:0] force_empty = '0;
    bit             rnd_mode = 1'b0;
    int             rptr[NCH];
    logic [DW-1:0]  dout_r[NCH];
    int             beats = 0;
    int             occ_err = 0;
    int             onehot_err = 0;
    int             empty_rd = 0;
    int             outstanding = 0;
    int             rd_cnt[NCH];

    // Channel word contents: tag, channel, frame number, word index.
    function automatic logic [DW-1:0] mk(input int fr, input int ch, input int w);
        return {4'hC, 4'(ch), 8'(fr), 16'(w)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Behavioural standard FIFOs: data valid the cycle after rd_en.
    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (fifo_clear) begin
                rptr[k] <= 0;
            end else if (fifo_rd_en[k]) begin
                dout_r[k] <= mk(frame_id, k, rptr[k]);
                rptr[k]   <= rptr[k] + 1;
            end
        end
    end

    always_comb begin
        fifo_dout  = '0;
        fifo_empty = '0;
        for (int k = 0; k < NCH; k++) begin
            fifo_dout[k*DW +: DW] = dout_r[k];
            fifo_empty[k] = (rptr[k] >= CNT) || force_empty[k];
        end
    end

    // Downstream ready: always ready, or a coin flip per cycle.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard compare on each handshake, hold-while-stalled,
    // read-strobe legality and outstanding-word occupancy.
    initial begin
        for (int k = 0; k < NCH; k++) rd_cnt[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) if (fifo_rd_en[k] === 1'b1) rd_cnt[k]++;
            if ($countones(fifo_rd_en) > 1) onehot_err++;
            if ((fifo_rd_en & fifo_empty) != '0) empty_rd++;
            if (outstanding > 2) occ_err++;
            if (prev_stall) chk("hold_while_stalled", {m_tvalid, m_tdata, m_tchan, m_tlast}, {1'b1, prev_beat});
            if (m_tvalid && m_tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_beat: got data %08h chan %0d, no word expected", m_tdata, m_tchan);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", {m_tdata, m_tchan, m_tlast}, mon_e);
                end
            end
            outstanding = outstanding + ((fifo_rd_en != '0) ? 1 : 0) - ((m_tvalid && m_tready) ? 1 : 0);
            prev_stall  = rst_n && m_tvalid && !m_tready;
            prev_beat   = {m_tdata, m_tchan, m_tlast};
            if (!rst_n) outstanding = 0;
        end
    end

    // Queue the expected words for mask and pulse start; leaves ch_mask scrambled.
    task automatic start_frame(input logic [NCH-1:0] mask, output int nexp);
        int    hi;
        beat_t b;
        hi   = -1;
        nexp = 0;
        for (int k = 0; k < NCH; k++) if (mask[k]) hi = k;
        @(posedge clk);
        #1;
        frame_id++;
        for (int k = 0; k < NCH; k++) begin
            for (int w = 0; w < CNT; w++) begin
                if (mask[k]) begin
                    b.d = mk(frame_id, k, w);
                    b.c = CW'(k);
                    b.l = (k == hi) && (w == CNT - 1);
                    exp_q.push_back(b);
                    nexp++;
                end
            end
        end
        fifo_clear = 1'b1;
        ch_mask    = mask;
        start      = 1'b1;
        @(posedge clk);
        #1;
        fifo_clear = 1'b0;
        start      = 1'b0;
        ch_mask    = ~mask;
    endtask

    task automatic run_frame(input logic [NCH-1:0] mask, input bit chk_lat, input bit contig, input int budget);
        int nexp, b0, occ0, oh0, er0, first_n, hs_n, done_n;
        int rc0[NCH];
        b0   = beats;
        occ0 = occ_err;
        oh0  = onehot_err;
        er0  = empty_rd;
        rc0  = rd_cnt;
        start_frame(mask, nexp);
        first_n = -1;
        hs_n    = -1;
        done_n  = -1;
        for (int n = 1; n <= budget && done_n < 0; n++) begin
            @(negedge clk);
            if (n == 1) chk("busy_at_t1", busy, (mask != '0));
            if (first_n < 0 && m_tvalid) first_n = n;
            if (m_tvalid && m_tready && m_tlast) hs_n = n;
            if (done) done_n = n;
        end
        chk("done_seen", (done_n >= 0), 1);
        if (nexp == 0) begin
            chk("done_latency_empty_mask", done_n, 1);
        end else begin
            chk("done_after_tlast", done_n, hs_n + 1);
            if (chk_lat) chk("first_valid_latency", first_n, 2);
            if (contig)  chk("contiguous_beats", hs_n - first_n + 1, nexp);
        end
        @(negedge clk);
        chk("done_one_cycle", {done, busy}, 0);
        chk("all_words_seen", exp_q.size(), 0);
        chk("beat_count", beats - b0, nexp);
        chk("occupancy_le_2", occ_err - occ0, 0);
        chk("rd_en_onehot", onehot_err - oh0, 0);
        chk("no_rd_while_empty", empty_rd - er0, 0);
        for (int k = 0; k < NCH; k++) chk("reads_per_channel", rd_cnt[k] - rc0[k], mask[k] ? CNT : 0);
    endtask

    // Stimulus sequence.
    initial begin
        int nexp, b0, guard;
        rst_n   = 1'b0;
        start   = 1'b0;
        ch_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {m_tvalid, m_tlast, m_tdata, m_tchan, fifo_rd_en, busy, done}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All channels, always ready
        run_frame(4'b1111, 1'b1, 1'b1, 100);
        // Channels 1 and 3 only
        run_frame(4'b1010, 1'b1, 1'b1, 100);
        // Random backpressure
        rnd_mode = 1'b1;
        run_frame(4'b1111, 1'b0, 1'b0, 400);
        run_frame(4'b0110, 1'b0, 1'b0, 400);
        rnd_mode = 1'b0;
        // Empty mask
        run_frame(4'b0000, 1'b0, 1'b0, 20);

        // Channel 2 runs dry for 10 cycles at word 3
        fork
            run_frame(4'b1111, 1'b1, 1'b0, 200);
            begin
                guard = 0;
                do begin
                    @(posedge clk);
                    #1;
                    guard++;
                end while (rptr[2] != 3 && guard < 200);
                chk("ch2_reached_word3", rptr[2], 3);
                force_empty[2] = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                chk("ch2_stalled_10_cycles", rptr[2], 3);
                force_empty[2] = 1'b0;
            end
        join

        // Reset mid-frame around beat 12, then a clean frame
        b0 = beats;
        start_frame(4'b1111, nexp);
        guard = 0;
        while ((beats - b0) < 12 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_beat_12", ((beats - b0) >= 12), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("outputs_after_midframe_reset", {m_tvalid, m_tlast, m_tdata, m_tchan, fifo_rd_en, busy, done}, 0);
        exp_q.delete();
        run_frame(4'b1111, 1'b1, 1'b1, 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
